cpu_ctrl_fsm: RTL and testbench

- Machine-cycle controller for the 8-bit RISC CPU.
- Sequences every instruction through 8 clock states: fetch, decode, operand, execute/writeback.
- Drives the PC, IR, accumulator and memory-bus strobes. Decides when ALU output (opcode-driven: ADD/AND/XOR/pass-data/pass-accum) is captured into the accumulator.
- Sits between the instruction register, the ALU zero flag and the datapath load/enable strobes.

---
 rtl/cpu_ctrl_pkg.sv | 34 +++
 rtl/cpu_ctrl_fsm_if.sv | 41 ++++
 rtl/cpu_ctrl_fsm.sv | 120 ++++++++++++
 tb/tb_cpu_ctrl_fsm.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode encodings, state encoding and widths for the CPU machine-cycle controller.
// Optional instruction counter (CPU_CTRL_INSTR_CNT_EN) uses CNT_W.
package cpu_ctrl_pkg;

    localparam int unsigned OP_W  = 3;
    localparam int unsigned CNT_W = 16;

    localparam logic [OP_W-1:0] HLT = 3'b000;
    localparam logic [OP_W-1:0] SKZ = 3'b001;
    localparam logic [OP_W-1:0] ADD = 3'b010;
    localparam logic [OP_W-1:0] AND = 3'b011;
    localparam logic [OP_W-1:0] XOR = 3'b100;
    localparam logic [OP_W-1:0] LDA = 3'b101;
    localparam logic [OP_W-1:0] STO = 3'b110;
    localparam logic [OP_W-1:0] JMP = 3'b111;

    typedef enum logic [3:0] {
        S0     = 4'd0,
        S1     = 4'd1,
        S2     = 4'd2,
        S3     = 4'd3,
        S4     = 4'd4,
        S5     = 4'd5,
        S6     = 4'd6,
        S7     = 4'd7,
        HALTED = 4'd8
    } state_t;

    // Opcodes whose result lands in the accumulator via the ALU.
    function automatic logic is_aluop(input logic [OP_W-1:0] op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_if.sv
// Controller <-> datapath bundle: run enable, IR opcode, zero flag and all datapath strobes.
// instr_cnt exists only when CPU_CTRL_INSTR_CNT_EN is defined.
interface cpu_ctrl_fsm_if;
    import cpu_ctrl_pkg::*;

    logic            ena;
    logic [OP_W-1:0] opcode;
    logic            zero;
    logic            sel;
    logic            rd;
    logic            ld_ir;
    logic            inc_pc;
    logic            ld_pc;
    logic            ld_ac;
    logic            data_e;
    logic            wr;
    logic            halt;

`ifdef CPU_CTRL_INSTR_CNT_EN
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        input  ena, opcode, zero,
        output sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt, instr_cnt
    );
    modport slave (
        output ena, opcode, zero,
        input  sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt, instr_cnt
    );
`else
    modport master (
        input  ena, opcode, zero,
        output sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt
    );
    modport slave (
        output ena, opcode, zero,
        input  sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt
    );
`endif

endinterface

// File: rtl/cpu_ctrl_fsm.sv
// Eight-state machine-cycle controller for the 8-bit RISC CPU; strobes decode from the state.
// Define CPU_CTRL_INSTR_CNT_EN to add the retired-instruction counter (instr_cnt).
module cpu_ctrl_fsm
    import cpu_ctrl_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    cpu_ctrl_fsm_if.master bus
);

    state_t state;
    state_t state_nxt;

    logic sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt;
    logic aluop, is_sto, is_jmp, skip;

    always_ff @(posedge clk) begin
        if (rst) state <= S0;
        else     state <= state_nxt;
    end

    // Next state and strobe decode; zero and opcode are used live, not latched.
    always_comb begin
        state_nxt = S0;
        sel       = 1'b0;
        rd        = 1'b0;
        ld_ir     = 1'b0;
        inc_pc    = 1'b0;
        ld_pc     = 1'b0;
        ld_ac     = 1'b0;
        data_e    = 1'b0;
        wr        = 1'b0;
        halt      = 1'b0;
        aluop     = is_aluop(bus.opcode);
        is_sto    = (bus.opcode == STO);
        is_jmp    = (bus.opcode == JMP);
        skip      = (bus.opcode == SKZ) && bus.zero;

        case (state)
            S0: begin
                sel       = 1'b1;
                state_nxt = bus.ena ? S1 : S0;
            end
            S1: begin
                sel       = 1'b1;
                rd        = 1'b1;
                state_nxt = S2;
            end
            S2: begin
                sel       = 1'b1;
                rd        = 1'b1;
                ld_ir     = 1'b1;
                state_nxt = S3;
            end
            S3: begin
                sel       = 1'b1;
                rd        = 1'b1;
                ld_ir     = 1'b1;
                state_nxt = S4;
            end
            S4: begin
                if (bus.opcode == HLT) begin
                    halt      = 1'b1;
                    state_nxt = HALTED;
                end else begin
                    inc_pc    = 1'b1;
                    state_nxt = S5;
                end
            end
            S5: begin
                rd        = aluop;
                state_nxt = S6;
            end
            S6: begin
                rd        = aluop;
                inc_pc    = skip;
                ld_pc     = is_jmp;
                data_e    = is_sto;
                state_nxt = S7;
            end
            S7: begin
                rd        = aluop;
                ld_ac     = aluop;
                inc_pc    = skip;
                ld_pc     = is_jmp;
                data_e    = is_sto;
                wr        = is_sto;
                state_nxt = S0;
            end
            HALTED: begin
                halt      = 1'b1;
                state_nxt = HALTED;
            end
            default: state_nxt = S0;
        endcase
    end

    assign bus.sel    = sel;
    assign bus.rd     = rd;
    assign bus.ld_ir  = ld_ir;
    assign bus.inc_pc = inc_pc;
    assign bus.ld_pc  = ld_pc;
    assign bus.ld_ac  = ld_ac;
    assign bus.data_e = data_e;
    assign bus.wr     = wr;
    assign bus.halt   = halt;

`ifdef CPU_CTRL_INSTR_CNT_EN
    logic [CNT_W-1:0] instr_cnt;

    // Counts completed instructions; S7 always retires into S0 unless reset intervenes.
    always_ff @(posedge clk) begin
        if (rst)              instr_cnt <= '0;
        else if (state == S7) instr_cnt <= instr_cnt + CNT_W'(1);
    end

    assign bus.instr_cnt = instr_cnt;
`endif

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Scoreboard bench for cpu_ctrl_fsm: stimulus queues expected strobe vectors, a negedge monitor checks them.
// Strobe vector order: {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt}.
module tb_cpu_ctrl_fsm;
    import cpu_ctrl_pkg::*;

    logic clk;
    logic rst;

    cpu_ctrl_fsm_if bus ();

    cpu_ctrl_fsm dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [8:0] V_S0   = 9'b100000000;
    localparam logic [8:0] V_S1   = 9'b110000000;
    localparam logic [8:0] V_S23  = 9'b111000000;
    localparam logic [8:0] V_INC  = 9'b000100000;
    localparam logic [8:0] V_NONE = 9'b000000000;
    localparam logic [8:0] V_RD   = 9'b010000000;
    localparam logic [8:0] V_RDAC = 9'b010001000;
    localparam logic [8:0] V_DE   = 9'b000000100;
    localparam logic [8:0] V_DEWR = 9'b000000110;
    localparam logic [8:0] V_JMP  = 9'b000010000;
    localparam logic [8:0] V_HALT = 9'b000000001;

    localparam logic [35:0] FETCH  = {V_S0, V_S1, V_S23, V_S23};
    localparam logic [71:0] ALU_V  = {FETCH, V_INC, V_RD, V_RD, V_RDAC};
    localparam logic [71:0] STO_V  = {FETCH, V_INC, V_NONE, V_DE, V_DEWR};
    localparam logic [71:0] SKZ1_V = {FETCH, V_INC, V_NONE, V_INC, V_INC};
    localparam logic [71:0] SKZ0_V = {FETCH, V_INC, V_NONE, V_NONE, V_NONE};
    localparam logic [71:0] JMP_V  = {FETCH, V_INC, V_NONE, V_JMP, V_JMP};
    localparam logic [71:0] HLT_V  = {FETCH, V_HALT, V_HALT, V_HALT, V_HALT};

    int total = 0;
    int bad   = 0;

    logic [8:0] exp_q[$];
    string      tag_q[$];
    logic [8:0] mon_exp;
    logic [8:0] mon_act;
    string      mon_tag;

`ifdef CPU_CTRL_INSTR_CNT_EN
    int exp_cnt = 0;
    task automatic cnt_inc(); exp_cnt++; endtask
    task automatic cnt_clr(); exp_cnt = 0; endtask
    task automatic chk_cnt(input string tag);
        total++;
        if (bus.instr_cnt !== CNT_W'(exp_cnt)) begin
            bad++;
            $display("FAIL %s instr_cnt got=%0d want=%0d", tag, bus.instr_cnt, exp_cnt);
        end
    endtask
`else
    task automatic cnt_inc(); endtask
    task automatic cnt_clr(); endtask
`endif

    // Queue the strobes expected in the current state, then advance one clock.
    task automatic step(input string tag, input logic [8:0] e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input string tag, input logic [OP_W-1:0] op, input logic z,
                             input logic [71:0] v);
        bus.opcode = op;
        bus.zero   = z;
        for (int i = 0; i < 8; i++) step($sformatf("%s_s%0d", tag, i), v[71-9*i -: 9]);
        cnt_inc();
    endtask

    // Monitor: strobes are stable mid-cycle, so compare on the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_exp = exp_q.pop_front();
            mon_tag = tag_q.pop_front();
            mon_act = {bus.sel, bus.rd, bus.ld_ir, bus.inc_pc, bus.ld_pc,
                       bus.ld_ac, bus.data_e, bus.wr, bus.halt};
            total++;
            if (mon_act !== mon_exp) begin
                bad++;
                $display("FAIL %s strobes got=%b want=%b", mon_tag, mon_act, mon_exp);
            end
        end
    end

    initial begin
        logic [71:0] v;
        rst        = 1'b1;
        bus.ena    = 1'b0;
        bus.opcode = ADD;
        bus.zero   = 1'b0;
        @(posedge clk);
        #1;
        step("reset", V_S0);
        rst     = 1'b0;
        bus.ena = 1'b1;
`ifdef CPU_CTRL_INSTR_CNT_EN
        chk_cnt("cnt_reset");
`endif

        run_instr("add",    ADD, 1'b0, ALU_V);
        run_instr("sto",    STO, 1'b0, STO_V);
        run_instr("skz_z1", SKZ, 1'b1, SKZ1_V);
        run_instr("skz_z0", SKZ, 1'b0, SKZ0_V);
        run_instr("jmp",    JMP, 1'b0, JMP_V);
        run_instr("xor",    XOR, 1'b1, ALU_V);
        run_instr("lda",    LDA, 1'b0, ALU_V);
        run_instr("and",    AND, 1'b0, ALU_V);

        // Reset during STO execute: the next cycle must be plain S0 with no write.
        bus.opcode = STO;
        bus.zero   = 1'b0;
        v = STO_V;
        for (int i = 0; i < 6; i++) step($sformatf("sto_rst_s%0d", i), v[71-9*i -: 9]);
        rst = 1'b1;
        step("sto_rst_s6", V_DE);
        rst = 1'b0;
        cnt_clr();
        run_instr("add_after_rst", ADD, 1'b0, ALU_V);

        // Drop ena in S2: instruction completes, then the FSM parks in S0.
        bus.opcode = ADD;
        v = ALU_V;
        for (int i = 0; i < 2; i++) step($sformatf("drop_s%0d", i), v[71-9*i -: 9]);
        bus.ena = 1'b0;
        for (int i = 2; i < 8; i++) step($sformatf("drop_s%0d", i), v[71-9*i -: 9]);
        cnt_inc();
        for (int i = 0; i < 3; i++) step($sformatf("park_%0d", i), V_S0);
        bus.ena = 1'b1;
        run_instr("add3", ADD, 1'b0, ALU_V);

        // HLT: halt from S4 onward, sticky regardless of opcode until reset.
        run_instr("hlt", HLT, 1'b0, HLT_V);
        cnt_clr();
        cnt_inc(); cnt_inc(); cnt_inc();
        bus.opcode = ADD;
        for (int i = 0; i < 20; i++) step($sformatf("halted_%0d", i), V_HALT);
`ifdef CPU_CTRL_INSTR_CNT_EN
        chk_cnt("cnt_halt");
`endif
        rst = 1'b1;
        step("halt_rst", V_HALT);
        rst     = 1'b0;
        bus.ena = 1'b0;
        cnt_clr();
`ifdef CPU_CTRL_INSTR_CNT_EN
        chk_cnt("cnt_after_rst");
`endif
        step("post_halt_s0", V_S0);
        bus.ena = 1'b1;
        run_instr("add_final", ADD, 1'b0, ALU_V);
`ifdef CPU_CTRL_INSTR_CNT_EN
        chk_cnt("cnt_final");
`endif

        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
